reg_write_arbiter: RTL and testbench

//  Round-robin write arbiter for one shared WIDTH-bit register. NREQ requesters
//  (e.g. ALU writeback, memory load, debug port) compete over a valid/ready handshake.

---
 rtl/reg_write_arbiter_pkg.sv | 11 +
 rtl/reg_write_arbiter_register.sv | 28 ++
 rtl/reg_write_arbiter.sv | 106 ++++++++++
 tb/tb_reg_write_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and helpers for the round-robin register write arbiter.
package reg_write_arbiter_pkg;

  localparam int MAX_NREQ = 16;

  // Width of a requester index; never below one bit.
  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_register.sv
// Generic loadable register with synchronous active-high reset.
module reg_write_arbiter_register #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) data_d = in_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) data_q <= RESET_VAL;
    else         data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one of NREQ writers access to a shared register,
// with an accepted-write counter and last-writer index.
import reg_write_arbiter_pkg::*;

module reg_write_arbiter #(
  parameter int               WIDTH     = 16,
  parameter int               NREQ      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_WIDTH = 8,
  localparam int              ID_W      = id_width(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]      reg_q_o,
  output logic [ID_W-1:0]       last_id_o,
  output logic [CNT_WIDTH-1:0]  wr_cnt_o,
  output logic                  busy_o
);

  // Handshake: a write from requester k is accepted on a rising edge where
  // req_valid_i[k] & req_ready_o[k]; ready never depends on data, and a valid
  // dropped before ready leaves no trace.

  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [ID_W-1:0]      last_id_q, last_id_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [NREQ-1:0]      grant;
  logic [ID_W-1:0]      win_id;
  logic [WIDTH-1:0]     win_data;
  logic                 accept;

  // Rotate so ptr sits at bit 0, keep the lowest set bit, rotate back.
  function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] valid,
                                               input logic [ID_W-1:0] ptr);
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   pick;
    logic [2*NREQ-1:0] back;
    dbl  = {valid, valid} >> ptr;
    rot  = dbl[NREQ-1:0];
    pick = rot & (~rot + {{(NREQ-1){1'b0}}, 1'b1});
    back = {pick, pick} << ptr;
    return back[2*NREQ-1:NREQ];
  endfunction

  always_comb begin
    grant = '0;
    if (reset_i) grant = rr_grant(req_valid_i, ptr_q);
  end

  always_comb begin
    win_id   = '0;
    win_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        win_id   = ID_W'(k);
        win_data = req_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign accept = |grant;

  always_comb begin
    ptr_d     = ptr_q;
    last_id_d = last_id_q;
    wr_cnt_d  = wr_cnt_q;
    if (accept) begin
      ptr_d     = (win_id == ID_W'(NREQ-1)) ? '0 : win_id + 1'b1;
      last_id_d = win_id;
      wr_cnt_d  = wr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      ptr_q     <= '0;
      last_id_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      last_id_q <= last_id_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  reg_write_arbiter_register #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_register (
    .clk_i   (clk_i),
    .reset_i (~reset_i),
    .load_i  (accept),
    .in_i    (win_data),
    .q_o     (reg_q_o)
  );

  assign req_ready_o = grant;
  assign last_id_o   = last_id_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign busy_o      = |req_valid_i;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: reset, single writer, rotation,
// wrap-around skip, reset-over-handshake and counter wrap.
module tb_reg_write_arbiter;

  localparam int WIDTH     = 16;
  localparam int NREQ      = 4;
  localparam int CNT_WIDTH = 8;

  logic                  clk_i = 1'b0;
  logic                  reset_i;
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ*WIDTH-1:0] req_data_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [WIDTH-1:0]      reg_q_o;
  logic [1:0]            last_id_o;
  logic [CNT_WIDTH-1:0]  wr_cnt_o;
  logic                  busy_o;

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] exp_q[$];

  reg_write_arbiter #(
    .WIDTH     (WIDTH),
    .NREQ      (NREQ),
    .RESET_VAL (16'h0000),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .reg_q_o     (reg_q_o),
    .last_id_o   (last_id_o),
    .wr_cnt_o    (wr_cnt_o),
    .busy_o      (busy_o)
  );

  // Clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change just after the falling edge; tick returns there too.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive(input logic rst_n, input logic [NREQ-1:0] v);
    reset_i     = rst_n;
    req_valid_i = v;
    #1;
  endtask

  task automatic set_data(input int k, input logic [WIDTH-1:0] d);
    req_data_i[k*WIDTH +: WIDTH] = d;
  endtask

  task automatic check_state(input string tag, input logic [WIDTH-1:0] r,
                             input logic [1:0] id, input logic [CNT_WIDTH-1:0] c);
    check({tag, "_reg"}, 32'(reg_q_o), 32'(r));
    check({tag, "_last"}, 32'(last_id_o), 32'(id));
    check({tag, "_cnt"}, 32'(wr_cnt_o), 32'(c));
  endtask

  // Scan-order reference: first valid at or after p, wrapping.
  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (p + i) % NREQ;
      if (v[k]) return NREQ'(1 << k);
    end
    return '0;
  endfunction

  initial begin
    logic [NREQ-1:0]  g;
    logic [WIDTH-1:0] d;
    int               mptr;
    int               win;

    reset_i     = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    @(negedge clk_i);

    // 1. Reset held two cycles with every requester valid
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < NREQ; k++) set_data(k, WIDTH'(16'hA000 + k));
      drive(1'b0, 4'b1111);
      check("rst_ready", 32'(req_ready_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h1);
      tick();
      check_state("rst", 16'h0000, 2'd0, 8'd0);
    end

    // 2. Single writer 2
    set_data(2, 16'hBEEF);
    drive(1'b1, 4'b0100);
    check("single_ready", 32'(req_ready_o), 32'h4);
    tick();
    check_state("single", 16'hBEEF, 2'd2, 8'd1);

    // Idle cycle: nothing granted, nothing changes
    drive(1'b1, 4'b0000);
    check("idle_ready", 32'(req_ready_o), 32'h0);
    check("idle_busy", 32'(busy_o), 32'h0);
    tick();
    check_state("idle", 16'hBEEF, 2'd2, 8'd1);

    // ptr is 3 now: with all valid, requester 3 wins first
    drive(1'b1, 4'b1111);
    check("ptr3_ready", 32'(req_ready_o), 32'h8);

    // 3. Rotation from a fresh pointer
    drive(1'b0, 4'b1111);
    tick();
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NREQ; k++) set_data(k, WIDTH'(((k + 1) << 12) + i));
      drive(1'b1, 4'b1111);
      check("rot_ready", 32'(req_ready_o), 32'(1 << (i % 4)));
      exp_q.push_back(WIDTH'((((i % 4) + 1) << 12) + i));
      tick();
      check("rot_reg", 32'(reg_q_o), 32'(exp_q.pop_front()));
      check("rot_last", 32'(last_id_o), 32'(i % 4));
    end
    check("rot_cnt", 32'(wr_cnt_o), 32'd8);

    // 4. Grant 1 (ptr -> 2), then only 0 valid: wraps past 2 and 3
    set_data(1, 16'h1111);
    drive(1'b1, 4'b0010);
    check("skip_g1", 32'(req_ready_o), 32'h2);
    tick();
    set_data(0, 16'h0A0A);
    drive(1'b1, 4'b0001);
    check("skip_g0", 32'(req_ready_o), 32'h1);
    tick();
    check_state("skip", 16'h0A0A, 2'd0, 8'd10);
    drive(1'b1, 4'b1111);
    check("skip_ptr1", 32'(req_ready_o), 32'h2);

    // 5. Reset coinciding with a would-be handshake
    drive(1'b0, 4'b0010);
    check("rstmid_ready", 32'(req_ready_o), 32'h0);
    tick();
    check_state("rstmid", 16'h0000, 2'd0, 8'd0);
    drive(1'b1, 4'b1111);
    check("rstmid_ptr0", 32'(req_ready_o), 32'h1);

    // 6. 256 random-pattern writes from reset; counter wraps to 0
    drive(1'b0, 4'b0000);
    tick();
    mptr = 0;
    for (int n = 0; n < 256; n++) begin
      for (int k = 0; k < NREQ; k++) set_data(k, WIDTH'($urandom_range(0, 16'hFFFF)));
      drive(1'b1, NREQ'($urandom_range(1, 15)));
      g = model_grant(req_valid_i, mptr);
      check("wrap_ready", 32'(req_ready_o), 32'(g));
      check("wrap_onehot", 32'($onehot0(req_ready_o)), 32'h1);
      check("wrap_subset", 32'(req_ready_o & ~req_valid_i), 32'h0);
      if (n == 255) check("wrap_cnt255", 32'(wr_cnt_o), 32'd255);
      win = 0;
      for (int k = 0; k < NREQ; k++) if (g[k]) win = k;
      d = req_data_i[win*WIDTH +: WIDTH];
      exp_q.push_back(d);
      mptr = (win == NREQ - 1) ? 0 : win + 1;
      tick();
      check("wrap_reg", 32'(reg_q_o), 32'(exp_q.pop_front()));
      check("wrap_last", 32'(last_id_o), 32'(win));
    end
    check("wrap_cnt0", 32'(wr_cnt_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
